// File: rtl/regfile_wb_arbiter.sv
// Writeback-port arbiter for the 32x32 register file: age-aware MD > LD > ALU grant,
// registered write stage, and a per-register pending scoreboard for RAW stalls.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned AGE_LIMIT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_waddr,
    input  logic [DATA_WIDTH-1:0] alu_wdata,
    output logic                  alu_ready,

    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_waddr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    input  logic [2:0]            ld_strb,
    output logic                  ld_ready,

    input  logic                  md_valid,
    input  logic [ADDR_WIDTH-1:0] md_waddr,
    input  logic [DATA_WIDTH-1:0] md_wdata,
    output logic                  md_ready,

    input  logic                  sb_set,
    input  logic [ADDR_WIDTH-1:0] sb_addr,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  busy1,
    output logic                  busy2,

    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [2:0]            rf_wstrb,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int unsigned NUM_REGS   = 1 << ADDR_WIDTH;
    localparam int unsigned AGE_WIDTH  = 4;
    localparam int unsigned STRB_WIDTH = 3;
    localparam logic [AGE_WIDTH-1:0]  AGE_MAX   = AGE_WIDTH'(AGE_LIMIT);
    localparam logic [STRB_WIDTH-1:0] STRB_FULL = 3'b011;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] waddr;
        logic [STRB_WIDTH-1:0] strb;
        logic [DATA_WIDTH-1:0] wdata;
    } wb_req_t;

    logic [AGE_WIDTH-1:0]  alu_age_q, alu_age_d;
    logic [AGE_WIDTH-1:0]  ld_age_q,  ld_age_d;
    logic [AGE_WIDTH-1:0]  md_age_q,  md_age_d;

    logic                  rf_wen_q,   rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [STRB_WIDTH-1:0] rf_wstrb_q, rf_wstrb_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    logic [NUM_REGS-1:0]   pending_q,  pending_d;

    logic    alu_aged, ld_aged, md_aged;
    logic    alu_gnt,  ld_gnt,  md_gnt;
    logic    sel_vld;
    wb_req_t sel_req;

    // Saturating wait counter; any cycle without a live, losing request restarts it.
    function automatic logic [AGE_WIDTH-1:0] next_age(
        input logic                 valid,
        input logic                 gnt,
        input logic [AGE_WIDTH-1:0] age
    );
        if (!valid || gnt) begin
            return '0;
        end
        if (age >= AGE_MAX) begin
            return AGE_MAX;
        end
        return age + AGE_WIDTH'(1);
    endfunction

    // Aged requesters form the upper priority tier; fixed MD > LD > ALU inside each tier.
    always_comb begin
        alu_gnt  = 1'b0;
        ld_gnt   = 1'b0;
        md_gnt   = 1'b0;
        alu_aged = alu_valid && (alu_age_q == AGE_MAX);
        ld_aged  = ld_valid  && (ld_age_q  == AGE_MAX);
        md_aged  = md_valid  && (md_age_q  == AGE_MAX);
        if (!reset) begin
            if (md_aged) begin
                md_gnt = 1'b1;
            end else if (ld_aged) begin
                ld_gnt = 1'b1;
            end else if (alu_aged) begin
                alu_gnt = 1'b1;
            end else if (md_valid) begin
                md_gnt = 1'b1;
            end else if (ld_valid) begin
                ld_gnt = 1'b1;
            end else if (alu_valid) begin
                alu_gnt = 1'b1;
            end
        end
    end

    assign alu_ready = alu_gnt;
    assign ld_ready  = ld_gnt;
    assign md_ready  = md_gnt;

    always_comb begin
        sel_vld = 1'b0;
        sel_req = '0;
        if (md_gnt) begin
            sel_vld = 1'b1;
            sel_req = '{waddr: md_waddr, strb: STRB_FULL, wdata: md_wdata};
        end else if (ld_gnt) begin
            sel_vld = 1'b1;
            sel_req = '{waddr: ld_waddr, strb: ld_strb, wdata: ld_wdata};
        end else if (alu_gnt) begin
            sel_vld = 1'b1;
            sel_req = '{waddr: alu_waddr, strb: STRB_FULL, wdata: alu_wdata};
        end
    end

    // Writes to register 0 complete the handshake but never reach the register file.
    always_comb begin
        rf_wen_d   = sel_vld && (sel_req.waddr != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wstrb_d = rf_wstrb_q;
        rf_wdata_d = rf_wdata_q;
        if (rf_wen_d) begin
            rf_waddr_d = sel_req.waddr;
            rf_wstrb_d = sel_req.strb;
            rf_wdata_d = sel_req.wdata;
        end
    end

    always_comb begin
        alu_age_d = next_age(alu_valid, alu_gnt, alu_age_q);
        ld_age_d  = next_age(ld_valid,  ld_gnt,  ld_age_q);
        md_age_d  = next_age(md_valid,  md_gnt,  md_age_q);
    end

    // Clear on the committing write first so a same-cycle set leaves the bit pending.
    always_comb begin
        pending_d = pending_q;
        if (rf_wen_q) begin
            pending_d[rf_waddr_q] = 1'b0;
        end
        if (sb_set && (sb_addr != '0)) begin
            pending_d[sb_addr] = 1'b1;
        end
    end

    assign busy1 = pending_q[raddr1] && (raddr1 != '0);
    assign busy2 = pending_q[raddr2] && (raddr2 != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_age_q  <= '0;
            ld_age_q   <= '0;
            md_age_q   <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wstrb_q <= STRB_FULL;
            rf_wdata_q <= '0;
            pending_q  <= '0;
        end else begin
            alu_age_q  <= alu_age_d;
            ld_age_q   <= ld_age_d;
            md_age_q   <= md_age_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wstrb_q <= rf_wstrb_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wstrb = rf_wstrb_q;
    assign rf_wdata = rf_wdata_q;

endmodule
